// File: rtl/icache_mshr_if.sv
// Bundle of the miss, memory request/response and fill signals of the I-cache MSHR.
// Port-style names keep the DUT's direction visible at every use site.
interface icache_mshr_if #(
    parameter int ENTRY_DEPTH   = 2,
    parameter int ADDR_WIDTH    = 26,
    parameter int NUM_WARP      = 8,
    parameter int WARP_ID_WIDTH = 3
);
    // Every channel moves one item on a rising edge where its valid and ready are both high;
    // a raised valid holds its payload steady until that edge, and ready never looks at payload.
    logic                     miss_valid_i;
    logic                     miss_ready_o;
    logic [ADDR_WIDTH-1:0]    miss_addr_i;
    logic [WARP_ID_WIDTH-1:0] miss_warp_i;
    logic                     mem_req_valid_o;
    logic                     mem_req_ready_i;
    logic [ADDR_WIDTH-1:0]    mem_req_addr_o;
    logic [ENTRY_DEPTH-1:0]   mem_req_id_o;
    logic                     mem_rsp_valid_i;
    logic [ENTRY_DEPTH-1:0]   mem_rsp_id_i;
    logic                     mem_rsp_ready_o;
    logic                     fill_valid_o;
    logic [ADDR_WIDTH-1:0]    fill_addr_o;
    logic [NUM_WARP-1:0]      fill_warp_mask_o;
    logic                     full_o;
    logic                     empty_o;

    modport master (
        output miss_valid_i, miss_addr_i, miss_warp_i, mem_req_ready_i,
               mem_rsp_valid_i, mem_rsp_id_i,
        input  miss_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_id_o,
               mem_rsp_ready_o, fill_valid_o, fill_addr_o, fill_warp_mask_o,
               full_o, empty_o
    );

    modport slave (
        input  miss_valid_i, miss_addr_i, miss_warp_i, mem_req_ready_i,
               mem_rsp_valid_i, mem_rsp_id_i,
        output miss_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_id_o,
               mem_rsp_ready_o, fill_valid_o, fill_addr_o, fill_warp_mask_o,
               full_o, empty_o
    );
endinterface

// File: rtl/icache_mshr.sv
// Instruction-cache miss status holding registers: merges warps missing on the same block,
// issues one memory read per block and pulses a fill/replay when the block returns.
module icache_mshr #(
    parameter int NUM_ENTRY     = 4,
    parameter int ENTRY_DEPTH   = 2,
    parameter int ADDR_WIDTH    = 26,
    parameter int NUM_WARP      = 8,
    parameter int WARP_ID_WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    icache_mshr_if.slave  bus
);
    logic [NUM_ENTRY-1:0]   valid_q,  valid_d;
    logic [NUM_ENTRY-1:0]   issued_q, issued_d;
    logic [ADDR_WIDTH-1:0]  addr_q [NUM_ENTRY];
    logic [ADDR_WIDTH-1:0]  addr_d [NUM_ENTRY];
    logic [NUM_WARP-1:0]    mask_q [NUM_ENTRY];
    logic [NUM_WARP-1:0]    mask_d [NUM_ENTRY];
    logic                   lock_q, lock_d;
    logic [ENTRY_DEPTH-1:0] lock_id_q, lock_id_d;
    logic                   fill_valid_q, fill_valid_d;
    logic [ADDR_WIDTH-1:0]  fill_addr_q, fill_addr_d;
    logic [NUM_WARP-1:0]    fill_mask_q, fill_mask_d;

    logic                     full, empty;
    logic [ENTRY_DEPTH-1:0]   rsp_id;
    logic [WARP_ID_WIDTH-1:0] miss_warp;
    logic [NUM_WARP-1:0]      warp_onehot;
    logic                     rsp_hit, miss_fire, req_valid, req_fire;
    logic [NUM_ENTRY-1:0]     rel;
    logic                     match_hit, pend_hit;
    logic [ENTRY_DEPTH-1:0]   match_idx, free_idx, pend_idx, sel_idx;

    assign full        = &valid_q;
    assign empty       = ~|valid_q;
    assign rsp_id      = bus.mem_rsp_id_i;
    assign miss_warp   = bus.miss_warp_i;
    assign warp_onehot = NUM_WARP'(1) << miss_warp;

    always_comb begin
        rsp_hit   = bus.mem_rsp_valid_i && valid_q[rsp_id] && issued_q[rsp_id];
        rel       = '0;
        if (rsp_hit) rel[rsp_id] = 1'b1;
        miss_fire = bus.miss_valid_i && !full;
        match_hit = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        pend_hit  = 1'b0;
        pend_idx  = '0;
        // Walk downwards so the lowest qualifying index wins.
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (valid_q[i] && !rel[i] && addr_q[i] == bus.miss_addr_i) begin
                match_hit = 1'b1;
                match_idx = ENTRY_DEPTH'(i);
            end
            if (!valid_q[i]) free_idx = ENTRY_DEPTH'(i);
            if (valid_q[i] && !issued_q[i]) begin
                pend_hit = 1'b1;
                pend_idx = ENTRY_DEPTH'(i);
            end
        end
        // A stalled request keeps its entry even if a lower index becomes pending meanwhile.
        sel_idx   = lock_q ? lock_id_q : pend_idx;
        req_valid = lock_q || pend_hit;
        req_fire  = req_valid && bus.mem_req_ready_i;
        lock_d    = req_valid && !bus.mem_req_ready_i;
        lock_id_d = sel_idx;

        valid_d  = valid_q;
        issued_d = issued_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        if (req_fire) issued_d[sel_idx] = 1'b1;
        if (rsp_hit) begin
            valid_d[rsp_id]  = 1'b0;
            issued_d[rsp_id] = 1'b0;
        end
        if (miss_fire) begin
            if (match_hit) begin
                mask_d[match_idx] = mask_q[match_idx] | warp_onehot;
            end else begin
                valid_d[free_idx]  = 1'b1;
                issued_d[free_idx] = 1'b0;
                addr_d[free_idx]   = bus.miss_addr_i;
                mask_d[free_idx]   = warp_onehot;
            end
        end

        fill_valid_d = rsp_hit;
        fill_addr_d  = rsp_hit ? addr_q[rsp_id] : '0;
        fill_mask_d  = rsp_hit ? mask_q[rsp_id] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            issued_q     <= '0;
            for (int i = 0; i < NUM_ENTRY; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
            end
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_mask_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            issued_q     <= issued_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_mask_q  <= fill_mask_d;
        end
    end

    // Stray responses (idle entry, or an id left over from before a reset) are dropped.
    always_ff @(posedge clk) begin
        if (!rst && bus.mem_rsp_valid_i) begin
            assert (rsp_hit)
            else $warning("icache_mshr: response to idle entry %0d dropped", rsp_id);
        end
    end

    assign bus.miss_ready_o     = !full;
    assign bus.mem_req_valid_o  = req_valid;
    assign bus.mem_req_addr_o   = addr_q[sel_idx];
    assign bus.mem_req_id_o     = sel_idx;
    assign bus.mem_rsp_ready_o  = 1'b1;
    assign bus.fill_valid_o     = fill_valid_q;
    assign bus.fill_addr_o      = fill_addr_q;
    assign bus.fill_warp_mask_o = fill_mask_q;
    assign bus.full_o           = full;
    assign bus.empty_o          = empty;
endmodule

// File: tb/tb_icache_mshr.sv
// Directed bench for icache_mshr: hand-computed expectations checked with immediate assertions.
module tb_icache_mshr;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    icache_mshr_if #(.ENTRY_DEPTH(2), .ADDR_WIDTH(26), .NUM_WARP(8), .WARP_ID_WIDTH(3)) bus ();

    icache_mshr #(
        .NUM_ENTRY(4), .ENTRY_DEPTH(2), .ADDR_WIDTH(26), .NUM_WARP(8), .WARP_ID_WIDTH(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a, input logic [31:0] id);
        chk({tag, ".req_valid"}, 32'(bus.mem_req_valid_o), 32'(v));
        chk({tag, ".req_addr"},  32'(bus.mem_req_addr_o), a);
        chk({tag, ".req_id"},    32'(bus.mem_req_id_o), id);
    endtask

    task automatic chk_fill(input string tag, input logic v, input logic [31:0] a, input logic [31:0] m);
        chk({tag, ".fill_valid"}, 32'(bus.fill_valid_o), 32'(v));
        chk({tag, ".fill_addr"},  32'(bus.fill_addr_o), a);
        chk({tag, ".fill_mask"},  32'(bus.fill_warp_mask_o), m);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".miss_ready"}, 32'(bus.miss_ready_o), 32'd1);
        chk({tag, ".req_valid"},  32'(bus.mem_req_valid_o), 32'd0);
        chk_fill(tag, 1'b0, 32'h0, 32'h0);
        chk({tag, ".full"},       32'(bus.full_o), 32'd0);
        chk({tag, ".empty"},      32'(bus.empty_o), 32'd1);
        chk({tag, ".rsp_ready"},  32'(bus.mem_rsp_ready_o), 32'd1);
    endtask

    task automatic miss(input logic [25:0] a, input logic [2:0] w);
        bus.miss_valid_i = 1'b1;
        bus.miss_addr_i  = a;
        bus.miss_warp_i  = w;
    endtask

    task automatic miss_off();
        bus.miss_valid_i = 1'b0;
        bus.miss_addr_i  = '0;
        bus.miss_warp_i  = '0;
    endtask

    task automatic rsp(input logic [1:0] id);
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_id_i    = id;
    endtask

    task automatic rsp_off();
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_id_i    = '0;
    endtask

    initial begin
        rst = 1'b1;
        miss_off();
        rsp_off();
        bus.mem_req_ready_i = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single miss, request, response, fill.
        miss(26'h100, 3'd2);
        bus.mem_req_ready_i = 1'b1;
        tick();
        miss_off();
        chk_req("single", 1'b1, 32'h100, 32'd0);
        chk("single.empty_busy", 32'(bus.empty_o), 32'd0);
        tick();
        chk("single.req_done", 32'(bus.mem_req_valid_o), 32'd0);
        rsp(2'd0);
        tick();
        rsp_off();
        chk_fill("single", 1'b1, 32'h100, 32'h04);
        chk("single.empty_after", 32'(bus.empty_o), 32'd1);
        tick();
        chk_fill("single_idle", 1'b0, 32'h0, 32'h0);

        // Two warps on one block merge into one request.
        bus.mem_req_ready_i = 1'b0;
        miss(26'h100, 3'd1);
        tick();
        miss(26'h100, 3'd5);
        chk_req("merge_a", 1'b1, 32'h100, 32'd0);
        tick();
        miss_off();
        chk_req("merge_b", 1'b1, 32'h100, 32'd0);
        bus.mem_req_ready_i = 1'b1;
        tick();
        chk("merge.one_req", 32'(bus.mem_req_valid_o), 32'd0);
        rsp(2'd0);
        tick();
        rsp_off();
        chk_fill("merge", 1'b1, 32'h100, 32'h22);
        tick();
        chk("merge.empty", 32'(bus.empty_o), 32'd1);

        // Fill the table while memory stalls; the request stays parked on id 0.
        bus.mem_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            miss(26'h200 + 26'(16 * i), 3'(i));
            tick();
            chk_req($sformatf("fill_table%0d", i), 1'b1, 32'h200, 32'd0);
        end
        miss_off();
        chk("full.full", 32'(bus.full_o), 32'd1);
        chk("full.miss_ready", 32'(bus.miss_ready_o), 32'd0);
        bus.mem_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_req($sformatf("issue_order%0d", i), 1'b1, 32'h200 + 32'(16 * i), 32'(i));
            tick();
        end
        chk("issue_order.done", 32'(bus.mem_req_valid_o), 32'd0);

        // Full table: a response frees entry 2, the waiting miss lands there a cycle later.
        miss(26'h300, 3'd4);
        rsp(2'd2);
        chk("full_rsp.miss_ready_blocked", 32'(bus.miss_ready_o), 32'd0);
        tick();
        rsp_off();
        chk_fill("full_rsp", 1'b1, 32'h220, 32'h04);
        chk("full_rsp.miss_ready_open", 32'(bus.miss_ready_o), 32'd1);
        tick();
        miss_off();
        chk_req("full_rsp_realloc", 1'b1, 32'h300, 32'd2);
        chk("full_rsp.full_again", 32'(bus.full_o), 32'd1);
        tick();
        chk("full_rsp.req_done", 32'(bus.mem_req_valid_o), 32'd0);
        rsp(2'd0);
        tick();
        chk_fill("drain0", 1'b1, 32'h200, 32'h01);
        rsp(2'd1);
        tick();
        chk_fill("drain1", 1'b1, 32'h210, 32'h02);
        rsp(2'd3);
        tick();
        chk_fill("drain3", 1'b1, 32'h230, 32'h08);
        rsp(2'd2);
        tick();
        chk_fill("drain2", 1'b1, 32'h300, 32'h10);
        rsp_off();
        tick();
        chk("drain.empty", 32'(bus.empty_o), 32'd1);
        chk_fill("drain_idle", 1'b0, 32'h0, 32'h0);

        // Miss to a block in the same cycle as its response: new entry, new request.
        miss(26'h100, 3'd3);
        tick();
        miss_off();
        chk_req("race_first", 1'b1, 32'h100, 32'd0);
        tick();
        chk("race.req_done", 32'(bus.mem_req_valid_o), 32'd0);
        miss(26'h100, 3'd6);
        rsp(2'd0);
        chk("race.miss_ready", 32'(bus.miss_ready_o), 32'd1);
        tick();
        miss_off();
        rsp_off();
        chk_fill("race_fill", 1'b1, 32'h100, 32'h08);
        chk_req("race_rereq", 1'b1, 32'h100, 32'd1);
        tick();
        chk("race.rereq_done", 32'(bus.mem_req_valid_o), 32'd0);
        rsp(2'd1);
        tick();
        rsp_off();
        chk_fill("race_refill", 1'b1, 32'h100, 32'h40);
        tick();
        chk("race.empty", 32'(bus.empty_o), 32'd1);

        // Reset with three outstanding misses; a late response is dropped.
        miss(26'h400, 3'd0);
        tick();
        miss(26'h410, 3'd1);
        tick();
        miss(26'h420, 3'd2);
        tick();
        miss_off();
        tick();
        chk("busy.empty", 32'(bus.empty_o), 32'd0);
        chk("busy.req_idle", 32'(bus.mem_req_valid_o), 32'd0);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        rst = 1'b0;
        rsp(2'd1);
        tick();
        rsp_off();
        chk_fill("late_rsp", 1'b0, 32'h0, 32'h0);
        chk("late_rsp.empty", 32'(bus.empty_o), 32'd1);
        tick();
        chk_fill("late_rsp_after", 1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
